// File: rtl/hack_pkg.sv
// hack_pkg: shared loader state encoding and Hack ROM geometry.
package hack_pkg;
    localparam int HACK_ADDR_WIDTH = 15;
    localparam int HACK_WORD_WIDTH = 16;
    localparam int HACK_ROM_WORDS = 32768;
    typedef enum logic [2:0] {IDLE, LOAD, FILL, HOLD, RUN, ERROR} state_t;
endpackage

// File: rtl/hack_rom_wr_port.sv
// hack_rom_wr_port: registered ROM write strobe/address/data stage shared by LOAD and FILL.
module hack_rom_wr_port #(
    parameter int ADDR_WIDTH = 15,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [WORD_WIDTH-1:0] rom_wdata
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rom_we <= 1'b0;
            rom_addr <= '0;
            rom_wdata <= '0;
        end else begin
            rom_we <= we;
            rom_addr <= addr;
            rom_wdata <= wdata;
        end
endmodule

// File: rtl/hack_rom_loader.sv
// hack_rom_loader: streams Hack instructions into ROM from address 0, zero-fills the tail,
// then releases the Computer from reset after a short hold.
module hack_rom_loader
    import hack_pkg::*;
#(
    parameter int ADDR_WIDTH = HACK_ADDR_WIDTH,
    parameter int WORD_WIDTH = HACK_WORD_WIDTH,
    parameter int FILL_TOP = HACK_ROM_WORDS,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [WORD_WIDTH-1:0] rom_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [ADDR_WIDTH:0] TOP = (ADDR_WIDTH + 1)'(FILL_TOP);
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);
    state_t state;
    logic [ADDR_WIDTH:0] ptr;
    logic [HW-1:0] hcnt;
    logic xfer;
    assign in_ready = state == LOAD;
    assign xfer = in_valid & in_ready;
    hack_rom_wr_port #(.ADDR_WIDTH(ADDR_WIDTH), .WORD_WIDTH(WORD_WIDTH)) u_wr (
        .clk(clk),
        .reset(reset),
        .we(xfer | (state == FILL)),
        .addr(ptr[ADDR_WIDTH-1:0]),
        .wdata(state == FILL ? '0 : in_data),
        .rom_we(rom_we),
        .rom_addr(rom_addr),
        .rom_wdata(rom_wdata)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            ptr <= '0;
            hcnt <= '0;
            cpu_reset <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
            word_count <= '0;
        end else begin
            hcnt <= state == HOLD ? hcnt + 1'b1 : '0;
            case (state)
                IDLE, RUN, ERROR:
                    if (start) begin
                        state <= LOAD;
                        ptr <= '0;
                        word_count <= '0;
                        cpu_reset <= 1'b1;
                        busy <= 1'b1;
                        done <= 1'b0;
                        error <= 1'b0;
                    end
                LOAD:
                    if (xfer) begin
                        ptr <= ptr + 1'b1;
                        word_count <= word_count == FULL ? word_count : word_count + 1'b1;
                        if (in_last) state <= ptr + 1'b1 >= TOP ? HOLD : FILL;
                        else if (ptr == LAST) begin
                            state <= ERROR;
                            busy <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                FILL: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == TOP - 1'b1) state <= HOLD;
                end
                HOLD:
                    // hcnt counts the strobe-free cycles after the final write becomes visible
                    if (hcnt == HW'(HOLD_CYCLES)) begin
                        state <= RUN;
                        cpu_reset <= 1'b0;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_hack_rom_loader.sv
// tb_hack_rom_loader: directed sessions against a per-cycle expected-output trace built from the load rules.
module tb_hack_rom_loader;
    localparam int TOP = 8;
    localparam int HOLD = 2;
    typedef struct {
        logic rdy, we;
        logic [2:0] addr;
        logic [15:0] data;
        logic cpu, bsy, dn, err;
        logic [3:0] wc;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic in_last = 1'b0;
    logic in_ready, rom_we, cpu_reset, busy, done, error;
    logic [2:0] rom_addr;
    logic [15:0] rom_wdata;
    logic [3:0] word_count;
    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    exp_t q[$];
    logic [15:0] wq[$];
    bit vq[$];
    logic [15:0] rom_img[TOP];

    hack_rom_loader #(.ADDR_WIDTH(3), .WORD_WIDTH(16), .FILL_TOP(TOP), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .rom_we(rom_we), .rom_addr(rom_addr),
        .rom_wdata(rom_wdata), .cpu_reset(cpu_reset), .busy(busy), .done(done),
        .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic push(input logic rdy, input logic we, input int addr, input logic [15:0] data,
                        input logic cpu, input logic bsy, input logic dn, input logic err, input int wc);
        exp_t e;
        e.rdy = rdy; e.we = we; e.addr = 3'(addr); e.data = data;
        e.cpu = cpu; e.bsy = bsy; e.dn = dn; e.err = err; e.wc = 4'(wc);
        q.push_back(e);
    endtask

    // Compare process: one expected entry per cycle while a session trace is pending
    always @(negedge clk) begin
        if (rom_we) begin
            rom_img[rom_addr] = rom_wdata;
            wr_count++;
        end
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("in_ready", 32'(in_ready), 32'(e.rdy));
            chk("rom_we", 32'(rom_we), 32'(e.we));
            if (e.we) begin
                chk("rom_addr", 32'(rom_addr), 32'(e.addr));
                chk("rom_wdata", 32'(rom_wdata), 32'(e.data));
            end
            chk("cpu_reset", 32'(cpu_reset), 32'(e.cpu));
            chk("busy", 32'(busy), 32'(e.bsy));
            chk("done", 32'(done), 32'(e.dn));
            chk("error", 32'(error), 32'(e.err));
            chk("word_count", 32'(word_count), 32'(e.wc));
        end
    end

    // Expected trace: each accepted word appears one cycle later at the next address; after the
    // last word, zeros up to TOP-1 on consecutive cycles, HOLD quiet cycles, then the CPU runs.
    task automatic session(input bit last, input int mid_start);
        int a = 0;
        int idx = 0;
        bit pw = 0;
        int pa = 0;
        logic [15:0] pd = '0;
        for (int i = 0; i < TOP; i++) rom_img[i] = 16'hFFFF;
        wr_count = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        foreach (vq[j]) begin
            push(1, pw, pa, pd, 1, 1, 0, 0, a);
            pw = vq[j];
            if (vq[j]) begin
                pa = a; pd = wq[a]; a++;
            end
        end
        if (!last) begin
            push(0, 1, pa, pd, 1, 0, 0, 1, a);
            push(0, 0, 0, 0, 1, 0, 0, 1, a);
        end else begin
            push(0, 1, pa, pd, 1, 1, 0, 0, a);
            for (int k = a; k < TOP; k++) push(0, 1, k, 0, 1, 1, 0, 0, a);
            for (int h = 0; h < HOLD; h++) push(0, 0, 0, 0, 1, 1, 0, 0, a);
            for (int r = 0; r < 3; r++) push(0, 0, 0, 0, 0, 0, 1, 0, a);
        end
        foreach (vq[j]) begin
            in_valid = vq[j];
            in_data = vq[j] ? wq[idx] : 16'hDEAD;
            in_last = vq[j] ? (last && idx == wq.size() - 1) : 1'b1;
            start = j == mid_start;
            if (vq[j]) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk); #1;
        chk("trace_drained", 32'(q.size()), 0);
    endtask

    initial begin
        #2 reset = 1'b0;
        #2;
        chk("rst_cpu_reset", 32'(cpu_reset), 1);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_rom_we", 32'(rom_we), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_rom_wdata", 32'(rom_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_word_count", 32'(word_count), 0);
        @(posedge clk); #3 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_rom_we", 32'(rom_we), 0);
            chk("idle_cpu_reset", 32'(cpu_reset), 1);
        end
        // Normal 3-word program
        wq = '{16'h0010, 16'hEC10, 16'h0011}; vq = '{1, 1, 1};
        session(1, -1); drain();
        chk("prog_w0", 32'(rom_img[0]), 32'h0010);
        chk("prog_w1", 32'(rom_img[1]), 32'hEC10);
        chk("prog_w2", 32'(rom_img[2]), 32'h0011);
        chk("prog_fill3", 32'(rom_img[3]), 0);
        chk("prog_fill7", 32'(rom_img[7]), 0);
        chk("prog_writes", 32'(wr_count), 8);
        chk("prog_count", 32'(word_count), 3);
        chk("prog_run", 32'({done, cpu_reset}), 32'b10);
        // Reload from RUN with gaps, in_last on idle slots and a start pulse mid-load
        wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555}; vq = '{1, 0, 1, 1, 0, 0, 1, 0, 1};
        session(1, 4); drain();
        chk("gap_w4", 32'(rom_img[4]), 32'h5555);
        chk("gap_fill5", 32'(rom_img[5]), 0);
        chk("gap_writes", 32'(wr_count), 8);
        chk("gap_count", 32'(word_count), 5);
        // Program exactly fills the ROM: no zero-fill
        wq = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'hA006, 16'hA007};
        vq = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
        session(1, -1); drain();
        chk("full_w7", 32'(rom_img[7]), 32'hA007);
        chk("full_writes", 32'(wr_count), 8);
        // Overflow: 8 words without in_last
        vq = '{1, 1, 1, 1, 1, 1, 1, 1};
        session(0, -1); drain();
        chk("ovf_w7", 32'(rom_img[7]), 32'hA007);
        chk("ovf_writes", 32'(wr_count), 8);
        chk("ovf_flags", 32'({error, in_ready, cpu_reset}), 32'b101);
        // Single-word program from ERROR
        wq = '{16'hABCD}; vq = '{1};
        session(1, -1); drain();
        chk("single_w0", 32'(rom_img[0]), 32'hABCD);
        chk("single_fill1", 32'(rom_img[1]), 0);
        chk("single_done", 32'({done, error}), 32'b10);
        // Asynchronous reset in the middle of FILL
        wq = '{16'h7777, 16'h8888}; vq = '{1, 1};
        session(1, -1);
        @(posedge clk); #2;
        chk("fill_active", 32'(rom_we), 1);
        q.delete();
        reset = 1'b0;
        #1;
        chk("abort_rom_we", 32'(rom_we), 0);
        chk("abort_cpu_reset", 32'(cpu_reset), 1);
        chk("abort_busy", 32'(busy), 0);
        @(posedge clk); @(posedge clk); #3 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_abort", 32'({done, busy, in_ready, rom_we, cpu_reset}), 32'b00001);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/hack_rom_loader.md
Name: hack_rom_loader

Overview:
- Write-side counterpart of the Hack computer's instruction-ROM fetch path.
- Accepts a stream of 16-bit Hack instruction words over a valid/ready handshake and writes them sequentially into instruction ROM from address 0.
- Zero-fills the unused tail of the ROM.
- Holds the Computer in reset during loading, then releases it so the program runs from pc=0.
- Replaces $readmemb preloading for synthesizable/bring-up flows.

Parameters:
ADDR_WIDTH, 15, ROM address width (Hack ROM is 32K words).
WORD_WIDTH, 16, instruction width.
FILL_TOP, 32768, zero-fill upper bound (exclusive); must be ≤ 2**ADDR_WIDTH.
HOLD_CYCLES, 2, cycles cpu_reset stays high after fill completes (min 1).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 = reset
start  in  1  one-cycle pulse: begin a new load session
in_valid  in  1  source has a word on in_data
in_data  in  WORD_WIDTH  instruction word
in_last  in  1  qualifies final word of the program
in_ready  out  1  loader accepts word this cycle
rom_we  out  1  ROM write strobe
rom_addr  out  ADDR_WIDTH  ROM write address
rom_wdata  out  WORD_WIDTH  ROM write data
cpu_reset  out  1  active-high reset to Computer
busy  out  1  session in progress
done  out  1  program loaded, CPU released
error  out  1  sticky overflow flag
word_count  out  ADDR_WIDTH+1  words accepted this session

Behaviour:
- Reset (reset=0, async): state=IDLE; cpu_reset=1; in_ready=0; rom_we=0; rom_addr=0; rom_wdata=0; busy=0; done=0; error=0; word_count=0. All outputs registered except in_ready.
- States: IDLE, LOAD, FILL, HOLD, RUN, ERROR.
- IDLE:
  - cpu_reset=1.
  - start → LOAD next cycle; addr ptr=0, word_count=0, error=0.
- LOAD:
  - in_ready=1 (combinational from state).
  - Transfer = in_valid & in_ready.
  - Each transfer: next cycle rom_we=1, rom_addr=ptr, rom_wdata=in_data; ptr and word_count increment (latency 1).
  - No transfer → rom_we=0 next cycle.
  - Transfer with in_last=1 → FILL, or HOLD if ptr+1 ≥ FILL_TOP.
  - Transfer at ptr=2**ADDR_WIDTH-1 without in_last → word is written, then ERROR.
- FILL:
  - in_ready=0.
  - One write per cycle: rom_we=1, rom_wdata=0, rom_addr=ptr, for ptr = word_count .. FILL_TOP-1.
  - After the write to FILL_TOP-1 → HOLD.
  - If word_count ≥ FILL_TOP, FILL is skipped.
- HOLD:
  - rom_we=0; cpu_reset=1 for exactly HOLD_CYCLES cycles (counter), then → RUN.
- RUN:
  - cpu_reset=0; done=1; busy=0.
  - start → LOAD; cpu_reset=1 and done=0 on the next edge; ptr and word_count cleared.
- ERROR:
  - error=1; cpu_reset=1; in_ready=0; rom_we=0.
  - start → LOAD (error cleared).
- busy=1 in LOAD, FILL and HOLD; 0 otherwise.
- start is ignored in LOAD, FILL and HOLD (no restart mid-session).
- in_last without in_valid is ignored.
- word_count saturates at 2**ADDR_WIDTH.
- Reset mid-session aborts immediately: cpu_reset=1, rom_we=0 asynchronously. ROM contents are undefined and a new start is required.
- Single-word program (in_valid & in_last in the first LOAD cycle) is legal.

Decomposition:
- Shared package hack_pkg: state enum (IDLE..ERROR), HACK_ADDR_WIDTH=15, HACK_WORD_WIDTH=16, HACK_ROM_WORDS=32768.
- One natural sub-module: hack_rom_wr_port, a registered write-strobe/address/data stage shared by LOAD and FILL.
- FSM and counters stay in the top module.

Test Plan:
- Reset, then release:
  - All outputs equal their reset values, with cpu_reset=1.
  - No rom_we for 10 cycles without start.
- Normal load (FILL_TOP=8, HOLD_CYCLES=2). Load the 3-word program 0x0010, 0xEC10, 0x0011 (last on the third):
  - Writes addr 0/1/2 with that data, 1 cycle after each accept.
  - Then addr 3..7 written with 0x0000.
  - cpu_reset stays 1 for 2 more cycles, then RUN: cpu_reset=0, done=1, word_count=3.
- Handshake gaps:
  - Drop in_valid randomly in LOAD: rom_we=0 in the cycle after each gap.
  - Address sequence stays contiguous, no duplicate writes.
- Overflow (ADDR_WIDTH=3, FILL_TOP=8): send 8 words with no in_last:
  - All 8 words written.
  - Then error=1, in_ready=0, cpu_reset=1.
  - A subsequent start clears error and re-enters LOAD.
- Reset mid-FILL: drive reset=0 asynchronously between clock edges:
  - rom_we drops and cpu_reset=1 immediately.
  - After release, state is IDLE with done=0.
- Reload from RUN: start while done=1:
  - cpu_reset rises on the next edge and the first new word is written to addr 0.
  - start pulses during LOAD have no effect.
